// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Field positions follow the 32-bit instruction encoding.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        EXEC = 2'd2
    } fetch_state_e;

    localparam int COND_HI  = 31;
    localparam int COND_LO  = 28;
    localparam int OP_HI    = 27;
    localparam int OP_LO    = 26;
    localparam int FUNCT_HI = 25;
    localparam int FUNCT_LO = 20;
    localparam int RN_HI    = 19;
    localparam int RN_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 12;
    localparam int SRC2_HI  = 11;
    localparam int SRC2_LO  = 0;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] PC_R15_OFFSET    = 32'd8;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, fetches one word per instruction
// and holds it in the instruction register for one execute cycle.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    input  logic        stall,
    output logic        exec_valid,
    output logic [31:0] instr,
    output logic [3:0]  cond,
    output logic [1:0]  op,
    output logic [5:0]  funct,
    output logic [3:0]  rn,
    output logic [3:0]  rd,
    output logic [11:0] src2,
    output logic [31:0] pc_plus8,
    output logic        misalign
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         misalign_q, misalign_d;

    // State register; reset aborts any fetch in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= REQ;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            misalign_q <= misalign_d;
        end
    end

    // Next-state logic: request, await response, execute, advance PC.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        misalign_d = misalign_q;
        unique case (state_q)
            REQ: begin
                if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    instr_d = imem_rsp_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    state_d = REQ;
                    if (pc_src) begin
                        pc_d = pc_target & ~32'h3;
                        if (pc_target[1:0] != 2'b00) begin
                            misalign_d = 1'b1;
                        end
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    // Request is gated by reset so it drops the moment reset asserts.
    assign imem_req_valid = rst_n && (state_q == REQ);
    assign imem_addr      = pc_q;
    assign exec_valid     = (state_q == EXEC);
    assign instr          = instr_q;
    assign misalign       = misalign_q;
    assign pc_plus8       = pc_q + PC_R15_OFFSET;

    assign cond  = instr_q[COND_HI:COND_LO];
    assign op    = instr_q[OP_HI:OP_LO];
    assign funct = instr_q[FUNCT_HI:FUNCT_LO];
    assign rn    = instr_q[RN_HI:RN_LO];
    assign rd    = instr_q[RD_HI:RD_LO];
    assign src2  = instr_q[SRC2_HI:SRC2_LO];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table walk plus
// hand sequences for back-pressure, reset abort and stall.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        stall;
    logic        exec_valid;
    logic [31:0] instr;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [31:0] pc_plus8;
    logic        misalign;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .pc_src         (pc_src),
        .pc_target      (pc_target),
        .stall          (stall),
        .exec_valid     (exec_valid),
        .instr          (instr),
        .cond           (cond),
        .op             (op),
        .funct          (funct),
        .rn             (rn),
        .rd             (rd),
        .src2           (src2),
        .pc_plus8       (pc_plus8),
        .misalign       (misalign)
    );

    typedef struct {
        logic [31:0] data;
        logic        src;
        logic [31:0] tgt;
        logic [31:0] addr;
        logic [31:0] pc8;
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] src2;
        logic [31:0] nxt;
        logic        mis;
    } vec_t;

    vec_t tv[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Entered at a negedge in REQ with ready high; leaves at the
    // negedge inside EXEC, checking the zero-wait-state timing.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
        chk("req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("req_addr", imem_addr, addr);
        chk("idle_exec", {31'b0, exec_valid}, 32'd0);
        @(negedge clk);
        chk("wait_noreq", {31'b0, imem_req_valid}, 32'd0);
        chk("wait_noexec", {31'b0, exec_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        chk("exec_valid", {31'b0, exec_valid}, 32'd1);
        chk("instr", instr, data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ev_cnt;
        logic [31:0] held;

        tv[0] = '{32'hE080_2003, 1'b0, 32'h0,
                  32'h0000_0000, 32'h0000_0008,
                  4'hE, 2'd0, 6'h08, 4'h0, 4'h2, 12'h003,
                  32'h0000_0004, 1'b0};
        tv[1] = '{32'h1234_5678, 1'b1, 32'h0000_0100,
                  32'h0000_0004, 32'h0000_000C,
                  4'h1, 2'd0, 6'h23, 4'h4, 4'h5, 12'h678,
                  32'h0000_0100, 1'b0};
        tv[2] = '{32'hFFFF_FFFF, 1'b1, 32'h0000_0102,
                  32'h0000_0100, 32'h0000_0108,
                  4'hF, 2'd3, 6'h3F, 4'hF, 4'hF, 12'hFFF,
                  32'h0000_0100, 1'b1};
        tv[3] = '{32'h5A5A_5A5A, 1'b1, 32'hFFFF_FFFC,
                  32'h0000_0100, 32'h0000_0108,
                  4'h5, 2'd2, 6'h25, 4'hA, 4'h5, 12'hA5A,
                  32'hFFFF_FFFC, 1'b1};
        tv[4] = '{32'h0000_0000, 1'b0, 32'h0000_0040,
                  32'hFFFF_FFFC, 32'h0000_0004,
                  4'h0, 2'd0, 6'h00, 4'h0, 4'h0, 12'h000,
                  32'h0000_0000, 1'b1};
        tv[5] = '{32'hA1B2_C3D4, 1'b0, 32'h0,
                  32'h0000_0000, 32'h0000_0008,
                  4'hA, 2'd0, 6'h1B, 4'h2, 4'hC, 12'h3D4,
                  32'h0000_0004, 1'b1};

        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        pc_src         = 1'b0;
        pc_target      = 32'h0;
        stall          = 1'b0;

        #12;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc8", pc_plus8, 32'h8);
        chk("rst_exec", {31'b0, exec_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_mis", {31'b0, misalign}, 32'd0);

        @(negedge clk);
        rst_n          = 1'b1;
        imem_req_ready = 1'b1;
        #1;

        for (int i = 0; i < 6; i++) begin
            fetch(tv[i].addr, tv[i].data);
            chk("cond", {28'b0, cond}, {28'b0, tv[i].cond});
            chk("op", {30'b0, op}, {30'b0, tv[i].op});
            chk("funct", {26'b0, funct}, {26'b0, tv[i].funct});
            chk("rn", {28'b0, rn}, {28'b0, tv[i].rn});
            chk("rd", {28'b0, rd}, {28'b0, tv[i].rd});
            chk("src2", {20'b0, src2}, {20'b0, tv[i].src2});
            chk("pc_plus8", pc_plus8, tv[i].pc8);
            pc_src    = tv[i].src;
            pc_target = tv[i].tgt;
            @(negedge clk);
            pc_src    = 1'b0;
            pc_target = 32'h0;
            chk("exec_one_cycle", {31'b0, exec_valid}, 32'd0);
            chk("next_addr", imem_addr, tv[i].nxt);
            chk("misalign", {31'b0, misalign}, {31'b0, tv[i].mis});
        end

        // Back-pressure: ready low for 3 cycles at PC=4.
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_req_valid", {31'b0, imem_req_valid}, 32'd1);
            chk("bp_addr", imem_addr, 32'h4);
        end
        imem_req_ready = 1'b1;
        fetch(32'h4, 32'h1111_1111);
        @(negedge clk);
        chk("bp_next_addr", imem_addr, 32'h8);

        // Reset while in WAIT, stale response arriving in REQ.
        @(negedge clk);
        chk("pre_rst_wait", {31'b0, imem_req_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("abort_addr", imem_addr, 32'h0);
        chk("abort_mis", {31'b0, misalign}, 32'd0);
        chk("abort_instr", instr, 32'h0);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stale_exec", {31'b0, exec_valid}, 32'd0);
            chk("stale_req", {31'b0, imem_req_valid}, 32'd1);
            chk("stale_addr", imem_addr, 32'h0);
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_req_ready = 1'b1;
        #1;
        fetch(32'h0, 32'hE1A0_0000);

        // Stall 4 cycles while the branch inputs toggle.
        held   = instr;
        ev_cnt = exec_valid ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            stall     = 1'b1;
            pc_src    = i[0];
            pc_target = 32'h0000_0201 + 32'(i * 16);
            @(negedge clk);
            if (exec_valid) ev_cnt++;
            chk("stall_instr", instr, held);
            chk("stall_addr", imem_addr, 32'h0);
        end
        stall     = 1'b0;
        pc_src    = 1'b1;
        pc_target = 32'h0000_0040;
        @(negedge clk);
        pc_src    = 1'b0;
        pc_target = 32'h0;
        if (exec_valid) ev_cnt++;
        chk("stall_exec_cycles", 32'(ev_cnt), 32'd5);
        chk("stall_next_addr", imem_addr, 32'h40);
        chk("stall_mis", {31'b0, misalign}, 32'd0);
        chk("stall_pc8", pc_plus8, 32'h48);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the single-cycle core. It sits directly upstream of the controller and datapath: it owns the PC, fetches one 32-bit instruction at a time over a valid/ready instruction-memory port, and holds it in an instruction register. It presents the decoded fields (cond, op, funct, register indices, Src2) for exactly one execute cycle, then advances the PC using the controller's `pc_src` and the datapath's branch target.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; must be word-aligned.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `imem_req_valid`  out  1: fetch request valid.
- `imem_req_ready`  in  1: memory accepts the request.
- `imem_addr`  out  32: fetch address, equal to the PC.
- `imem_rsp_valid`  in  1: read data valid.
- `imem_rsp_data`  in  32: instruction word.
- `pc_src`  in  1: from the controller; 1 means take `pc_target`.
- `pc_target`  in  32: branch/PC-write target from the ALU result.
- `stall`  in  1: the datapath holds the current execute cycle (data-memory busy).
- `exec_valid`  out  1: the instruction register holds a live instruction; qualifies regWrite, memWrite and flag writes.
- `instr`  out  32: instruction register.
- `cond`  out  4: instr[31:28].
- `op`  out  2: instr[27:26].
- `funct`  out  6: instr[25:20].
- `rn`  out  4: instr[19:16].
- `rd`  out  4: instr[15:12].
- `src2`  out  12: instr[11:0].
- `pc_plus8`  out  32: PC+8, the architectural R15 read value.
- `misalign`  out  1: sticky flag; a non-word-aligned target was taken.

## Operation
- FSM states: REQ, WAIT, EXEC. Reset state is REQ.
- REQ: `imem_req_valid`=1 and `imem_addr`=PC. On `imem_req_valid & imem_req_ready`, go to WAIT. `imem_addr` stays stable while the request is pending. `imem_rsp_valid` in REQ is ignored, so a response left over from before a reset is dropped.
- WAIT: `imem_req_valid`=0. On `imem_rsp_valid`, capture `imem_rsp_data` into `instr` and go to EXEC.
- EXEC: `exec_valid`=1.
  - `stall`=1: remain in EXEC; `instr` and PC hold and `pc_src`/`pc_target` are not sampled.
  - `stall`=0: update the PC and go to REQ. PC becomes `pc_target & ~32'h3` if `pc_src`=1, otherwise PC+4.
- Misalignment: if `pc_src`=1 and `pc_target[1:0]`≠0 when the PC updates, set `misalign`. It clears only on reset.
- Arithmetic is 32-bit modulo. PC+4 from 32'hFFFF_FFFC wraps to 0. `pc_plus8` wraps the same way.
- Field outputs are pure slices of `instr`.

## Timing
- Reset values:
  - state REQ; PC=`RESET_PC`; `instr`=0; `exec_valid`=0; `misalign`=0.
  - `imem_req_valid`=0 while `rst_n`=0, then 1 in the first cycle after deassertion.
  - `imem_addr`=`RESET_PC`; `pc_plus8`=`RESET_PC`+8.
- Fastest cycle: request accepted in cycle N, response in N+1 (never earlier), EXEC in N+2, next request in N+3. That gives 3 cycles per instruction with zero memory wait.
- `exec_valid` is high for exactly 1 cycle plus 1 per stalled cycle.
- The new PC is visible on `imem_addr` in the cycle after EXEC exits.
- Reset asserted in any state aborts immediately. Outputs take their reset values asynchronously, and no partial PC update happens.

## Structure
- Package `fetch_pkg` holds:
  - the state enum (REQ/WAIT/EXEC);
  - bit-position constants for the cond/op/funct/rn/rd/src2 fields;
  - the default `RESET_PC`;
  - the constant 4 and the PC+8 offset.
- Single module; no sub-module is warranted. Field slicing stays inline.

## Test plan
- Reset release with `RESET_PC`=0 and ready tied high, rsp one cycle after acceptance carrying 32'hE080_2003 -> `cond`=4'hE, `op`=0, `funct`=6'h08, `rn`=0, `rd`=2, `src2`=12'h003; `exec_valid` high for 1 cycle; next `imem_addr`=4.
- `imem_req_ready` low for 3 cycles -> `imem_addr` is stable and `imem_req_valid` stays high throughout; WAIT is entered only after acceptance.
- EXEC with `pc_src`=1, `pc_target`=32'h0000_0100 -> next fetch at 0x100 and `pc_plus8`=0x108. Repeat with target 0x102 -> fetch at 0x100 and `misalign`=1, which persists.
- `stall`=1 for 4 cycles in EXEC while `pc_src`/`pc_target` toggle -> `exec_valid` is high for 5 cycles, `instr` is unchanged, and the PC is updated only from the values at the final cycle.
- PC=32'hFFFF_FFFC with `pc_src`=0 -> next `imem_addr`=0; `pc_plus8` at 0xFFFF_FFFC reads 0x0000_0004.
- Assert `rst_n` in WAIT, release, and have stale `imem_rsp_valid` arrive in REQ -> the response is ignored, a fetch at `RESET_PC` is issued, and `exec_valid` stays 0 until the fresh response arrives.
